// File: rtl/cdm_pkg.sv
// Shared definitions for the carry-disregard multiplier.
// Mode encoding and a behavioural golden model.
package cdm_pkg;

  localparam logic CDM_APPROX = 1'b0;
  localparam logic CDM_EXACT  = 1'b1;

  // Golden model: columns below k are carry-free ORs,
  // columns at or above k are summed exactly.
  function automatic logic [63:0] cdm_ref(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w,
    input int          k
  );
    logic [63:0] hi;
    logic [63:0] lo;
    logic [63:0] t;
    hi = '0;
    lo = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        if (i < w && j < w && a[i] && b[j]) begin
          t = 64'd1 << (i + j);
          if (i + j >= k) hi = hi + t;
          else            lo = lo | t;
        end
      end
    end
    return hi + lo;
  endfunction

endpackage

// File: rtl/cdm_col_reduce.sv
// Partial-product reduction for the CDM multiplier.
// Low columns are OR-ed, high columns carry-saved.
module cdm_col_reduce
  import cdm_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           mode_i,
  output logic [2*W-1:0] hs_o,
  output logic [2*W-1:0] hc_o,
  output logic [2*W-1:0] lo_o
);

  localparam int N = 2 * W;
  localparam logic [N-1:0] LO_MASK =
    {N{1'b1}} >> (N - APPROX_COLS);

  logic [N-1:0] mask;
  logic [N-1:0] row;
  logic [N-1:0] s;
  logic [N-1:0] c;
  logic [N-1:0] t;

  // Split each shifted row into carry-free low bits and a
  // carry-save accumulated high part; exact mode masks nothing.
  always_comb begin
    mask = (mode_i == CDM_EXACT) ? '0 : LO_MASK;
    row  = '0;
    t    = '0;
    s    = '0;
    c    = '0;
    lo_o = '0;
    for (int j = 0; j < W; j++) begin
      row  = b_i[j] ? (N'(a_i) << j) : '0;
      lo_o = lo_o | (row & mask);
      row  = row & ~mask;
      t    = s ^ c ^ row;
      c    = ((s & c) | (s & row) | (c & row)) << 1;
      s    = t;
    end
    hs_o = s;
    hc_o = c;
  end

endmodule

// File: rtl/cdm_pipe_mult.sv
// Pipelined carry-disregard approximate multiplier.
// Global-stall valid/ready pipeline of STAGES registers.
module cdm_pipe_mult
  import cdm_pkg::*;
#(
  parameter int W           = 8,
  parameter int APPROX_COLS = 8,
  parameter int STAGES      = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_r,
  output logic           out_mode
);

  localparam int N = 2 * W;

  typedef struct packed {
    logic         v;
    logic         m;
    logic         cy;
    logic [N-1:0] x;
    logic [N-1:0] y;
  } stg_t;

  stg_t [STAGES-1:0] st_q;

  logic         adv;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rm;
  logic [N-1:0] hs;
  logic [N-1:0] hc;
  logic [N-1:0] lo;
  logic [N-1:0] hl;
  logic         unused_st;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign unused_st = ^st_q;

  // Reduction reads raw inputs when single-stage, else stage 0
  always_comb begin
    if (STAGES == 1) begin
      ra = in_a;
      rb = in_b;
      rm = in_mode;
    end else begin
      ra = st_q[0].x[W-1:0];
      rb = st_q[0].y[W-1:0];
      rm = st_q[0].m;
    end
  end

  cdm_col_reduce #(
    .W          (W),
    .APPROX_COLS(APPROX_COLS)
  ) u_red (
    .a_i   (ra),
    .b_i   (rb),
    .mode_i(rm),
    .hs_o  (hs),
    .hc_o  (hc),
    .lo_o  (lo)
  );

  // Low bits of the carry vector are always zero, so OR is add
  assign hl = hc | lo;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    stg_t d;
    stg_t q;

    if (i == 0) begin : g_in
      // Entry: operands, or finished product when single-stage
      always_comb begin
        d   = '0;
        d.v = in_valid;
        d.m = in_mode;
        if (STAGES == 1) begin
          d.x = hs + hl;
        end else begin
          d.x = N'(in_a);
          d.y = N'(in_b);
        end
      end
    end else if (i == 1) begin : g_red
      // Capture carry-save pair, or finish the add if last
      always_comb begin
        d   = '0;
        d.v = st_q[i-1].v;
        d.m = st_q[i-1].m;
        if (STAGES == 2) begin
          d.x = hs + hl;
        end else begin
          d.x = hs;
          d.y = hl;
        end
      end
    end else if (i == 2 && STAGES == 3) begin : g_add
      // Single final carry-propagate add
      always_comb begin
        d   = '0;
        d.v = st_q[i-1].v;
        d.m = st_q[i-1].m;
        d.x = st_q[i-1].x + st_q[i-1].y;
      end
    end else if (i == 2) begin : g_lo
      logic [W:0] lsum;
      // Lower half of the final add, carry kept aside
      always_comb begin
        lsum = {1'b0, st_q[i-1].x[W-1:0]}
             + {1'b0, st_q[i-1].y[W-1:0]};
        d    = '0;
        d.v  = st_q[i-1].v;
        d.m  = st_q[i-1].m;
        d.x  = {st_q[i-1].x[N-1:W], lsum[W-1:0]};
        d.y  = {st_q[i-1].y[N-1:W], {W{1'b0}}};
        d.cy = lsum[W];
      end
    end else begin : g_hi
      // Upper half of the final add plus the lower carry
      always_comb begin
        d   = '0;
        d.v = st_q[i-1].v;
        d.m = st_q[i-1].m;
        d.x = {st_q[i-1].x[N-1:W]
             + st_q[i-1].y[N-1:W]
             + {{(W-1){1'b0}}, st_q[i-1].cy},
               st_q[i-1].x[W-1:0]};
      end
    end

    // Stage register: cleared on reset, shifts only on advance
    always_ff @(posedge clk) begin
      if (rst)      q <= '0;
      else if (adv) q <= d;
    end

    assign st_q[i] = q;
  end

  assign out_valid = st_q[STAGES-1].v;
  assign out_r     = out_valid ? st_q[STAGES-1].x : '0;
  assign out_mode  = out_valid & st_q[STAGES-1].m;

endmodule

// File: tb/tb_cdm_pipe_mult.sv
// Scoreboard bench for cdm_pipe_mult (W=8, K=8, 3 stages).
// Directed vectors, random stalls and mid-stream reset.
module tb_cdm_pipe_mult;
  import cdm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic        out_mode;

  typedef struct {
    logic [15:0] r;
    logic        m;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] r;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;

  vec_t vecs[18] = '{
    '{8'd3,   8'd3,   1'b0, 16'd7},
    '{8'd3,   8'd3,   1'b1, 16'd9},
    '{8'd255, 8'd255, 1'b0, 16'd63487},
    '{8'd255, 8'd255, 1'b1, 16'd65025},
    '{8'd16,  8'd16,  1'b0, 16'd256},
    '{8'd16,  8'd16,  1'b1, 16'd256},
    '{8'd5,   8'd5,   1'b0, 16'd21},
    '{8'd5,   8'd5,   1'b1, 16'd25},
    '{8'd240, 8'd15,  1'b0, 16'd3056},
    '{8'd240, 8'd15,  1'b1, 16'd3600},
    '{8'd15,  8'd15,  1'b0, 16'd127},
    '{8'd15,  8'd15,  1'b1, 16'd225},
    '{8'd3,   8'd7,   1'b0, 16'd15},
    '{8'd3,   8'd7,   1'b1, 16'd21},
    '{8'd0,   8'd200, 1'b0, 16'd0},
    '{8'd1,   8'd200, 1'b0, 16'd200},
    '{8'd128, 8'd128, 1'b0, 16'd16384},
    '{8'd255, 8'd1,   1'b0, 16'd255}
  };

  cdm_pipe_mult #(
    .W          (8),
    .APPROX_COLS(8),
    .STAGES     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_mode (out_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic drive(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic m,
                       input logic [15:0] er,
                       input bit lat);
    int   tries;
    exp_t e;
    tries = 0;
    in_a = a;
    in_b = b;
    in_mode = m;
    in_valid = 1'b1;
    forever begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) break;
      @(negedge clk);
      tries++;
      if (tries > 500) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    e.r = er;
    e.m = m;
    e.cyc = cyc;
    e.lat = lat;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: pop and compare on every output transfer
  initial begin : monitor
    exp_t        e;
    bit          pst;
    bit          prst;
    logic [15:0] pr;
    logic        pm;
    pst = 0;
    prst = 1;
    pr = '0;
    pm = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (!out_valid) chk("idle_out_r", out_r, 0);
      if (pst && !prst) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_r", out_r, pr);
        chk("stall_mode", out_mode, pm);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got out_r=%0d required none", out_r);
        end else begin
          e = exp_q.pop_front();
          chk("out_r", out_r, e.r);
          chk("out_mode", out_mode, e.m);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
      pst = out_valid && !out_ready;
      prst = rst;
      pr = out_r;
      pm = out_mode;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [63:0] rv;
    logic [15:0] er;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mode = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_mode", out_mode, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    foreach (vecs[i])
      drive(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, 1'b1);
    wait_drain();

    rand_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        m = 1'($urandom_range(0, 1));
        if (m == CDM_EXACT) begin
          er = 16'(a) * 16'(b);
        end else begin
          rv = cdm_ref({24'd0, a}, {24'd0, b}, 8, 8);
          er = rv[15:0];
        end
        drive(a, b, m, er, 1'b0);
      end
    end
    rand_rdy = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    out_ready = 1'b0;
    drive(8'd10, 8'd20, 1'b1, 16'd200, 1'b0);
    drive(8'd30, 8'd40, 1'b1, 16'd1200, 1'b0);
    drive(8'd50, 8'd60, 1'b1, 16'd3000, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_r", out_r, 0);
    chk("mid_rst_out_mode", out_mode, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    drive(8'd3, 8'd3, 1'b0, 16'd7, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
